// File: rtl/qam_tx_pkg.sv
// Shared constants and types for the QAM-16 transmit datapath.
// Sample format, I/Q packing, upsample defaults and upsampler mode encodings.
package qam_tx_pkg;

  localparam int SAMPLE_W     = 16;
  localparam int IQ_CH        = 2;
  localparam int UPSAMPLE_DEF = 4;

  localparam logic MODE_ZERO = 1'b0;
  localparam logic MODE_HOLD = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } us_state_t;

  // Counter width for a modulo-n phase; at least one bit so n==1 still has a register.
  function automatic int phase_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/upsample_phase_ctr.sv
// Wrap counter 0..MAX-1 with synchronous clear (priority) and increment; last flags MAX-1.
// Single-cycle update; no flow control of its own, the caller gates inc.
module upsample_phase_ctr
  import qam_tx_pkg::*;
#(
  parameter int MAX   = UPSAMPLE_DEF,
  parameter int CNT_W = phase_w(MAX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] phase,
  output logic             last
);

  localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(MAX - 1);

  assign last = (phase == LAST_VAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (inc) begin
      phase <= last ? '0 : phase + 1'b1;
    end
  end

endmodule

// File: rtl/zero_stuffer_iq.sv
// I/Q upsampler: one symbol in, UPSAMPLE beats out (zero-stuffed or held); first beat the cycle after load.
// Full valid/ready backpressure, gapless reload on the last beat; in_ready is combinational from out_ready.
module zero_stuffer_iq
  import qam_tx_pkg::*;
#(
  parameter int WIDTH    = SAMPLE_W,
  parameter int CHANNELS = IQ_CH,
  parameter int UPSAMPLE = UPSAMPLE_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      mode,
  input  logic [WIDTH*CHANNELS-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH*CHANNELS-1:0] out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_first
);

  localparam int PH_W = phase_w(UPSAMPLE);

  us_state_t                          state;
  logic [CHANNELS-1:0][WIDTH-1:0]     hold_q;
  logic                               mode_q;
  logic [PH_W-1:0]                    phase;
  logic                               last;
  logic                               load;
  logic                               fire;
  logic                               ph0;

  assign in_ready = en & ~clr & ((state == ST_IDLE) | (last & out_ready));
  assign load     = in_valid & in_ready;
  assign fire     = out_valid & out_ready;
  assign ph0      = (phase == '0);

  // A load always restarts at phase 0; on a last-beat fire the counter wraps there anyway.
  upsample_phase_ctr #(
    .MAX   (UPSAMPLE),
    .CNT_W (PH_W)
  ) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr | load),
    .inc   (fire),
    .phase (phase),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold_q    <= '0;
      mode_q    <= MODE_ZERO;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= ST_IDLE;
      hold_q    <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load) begin
            hold_q    <= in_data;
            mode_q    <= mode;
            state     <= ST_EMIT;
            out_valid <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (fire && last) begin
            if (load) begin
              hold_q <= in_data;
              mode_q <= mode;
            end else begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_first = out_valid & ph0;

  // Phase 0 always carries the sample; later phases carry it only in hold mode.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign out_data[c*WIDTH +: WIDTH] =
      (out_valid && (ph0 || (mode_q == MODE_HOLD))) ? hold_q[c] : '0;
  end

endmodule

// File: tb/tb_zero_stuffer_iq.sv
// Randomized and directed bench for zero_stuffer_iq at UPSAMPLE=4 and UPSAMPLE=1, checked against a beat-queue model.
module tb_zero_stuffer_iq;

  typedef struct {
    logic [31:0] dat;
    logic        first;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, clr, mode, in_valid, out_ready;
  logic [31:0] in_data;

  logic        ir4, ov4, of4;
  logic [31:0] od4;
  logic        ir1, ov1, of1;
  logic [31:0] od1;

  beat_t q4[$];
  beat_t q1[$];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  zero_stuffer_iq #(.WIDTH(16), .CHANNELS(2), .UPSAMPLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .out_first(of4)
  );

  zero_stuffer_iq #(.WIDTH(16), .CHANNELS(2), .UPSAMPLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .mode(mode),
    .in_data(in_data), .in_valid(in_valid), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_first(of1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The block may accept when it is empty, or when its final beat leaves this cycle.
  function automatic logic exp_ready(input int sz);
    return en & ~clr & rst_n & ((sz == 0) | ((sz == 1) & out_ready));
  endfunction

  task automatic check_all();
    beat_t h4, h1;
    h4.dat = '0; h4.first = 1'b0;
    h1.dat = '0; h1.first = 1'b0;
    if (q4.size() > 0) h4 = q4[0];
    if (q1.size() > 0) h1 = q1[0];
    chk("u4_in_ready",  32'(ir4), 32'(rst_n ? exp_ready(q4.size()) : en));
    chk("u4_out_valid", 32'(ov4), 32'(q4.size() > 0));
    chk("u4_out_data",  od4, h4.dat);
    chk("u4_out_first", 32'(of4), 32'(h4.first));
    chk("u1_in_ready",  32'(ir1), 32'(rst_n ? exp_ready(q1.size()) : en));
    chk("u1_out_valid", 32'(ov1), 32'(q1.size() > 0));
    chk("u1_out_data",  od1, h1.dat);
    chk("u1_out_first", 32'(of1), 32'(h1.first));
  endtask

  // Deliver, abort, then enqueue the beats a newly loaded symbol expands into.
  task automatic model_edge(input int up);
    int    sz;
    logic  rdy, fire, load;
    beat_t b;
    sz   = (up == 4) ? q4.size() : q1.size();
    rdy  = exp_ready(sz);
    fire = (sz > 0) & out_ready;
    load = in_valid & rdy;
    if (fire) begin
      if (up == 4) void'(q4.pop_front()); else void'(q1.pop_front());
    end
    if (clr) begin
      if (up == 4) q4.delete(); else q1.delete();
    end
    if (load) begin
      for (int j = 0; j < up; j++) begin
        b.dat   = (j == 0 || mode) ? in_data : 32'h0;
        b.first = (j == 0);
        if (up == 4) q4.push_back(b); else q1.push_back(b);
      end
    end
  endtask

  task automatic cyc();
    #1;
    check_all();
    @(posedge clk);
    if (!rst_n) begin
      q4.delete();
      q1.delete();
    end else begin
      model_edge(4);
      model_edge(1);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b1; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_data = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Single zero-stuffed symbol, full throughput downstream
    in_valid = 1'b1; mode = 1'b0; in_data = 32'hFEDC_1234;
    cyc();
    in_valid = 1'b0;
    repeat (6) cyc();

    // Three back-to-back held symbols
    mode = 1'b1; in_valid = 1'b1;
    repeat (12) begin
      in_data = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();

    // Random downstream stalls
    in_valid = 1'b1;
    repeat (48) begin
      mode      = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();

    // Abort on beat 2, then a fresh symbol
    mode = 1'b1; in_valid = 1'b1; in_data = 32'hA5A5_5A5A;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0; in_valid = 1'b1; in_data = 32'h0BAD_CAFE; mode = 1'b0;
    cyc();
    in_valid = 1'b0;
    repeat (5) cyc();

    // Enable dropped on beat 1 while input keeps offering
    in_valid = 1'b1; in_data = 32'h1111_2222; mode = 1'b1;
    cyc();
    cyc();
    en = 1'b0;
    repeat (7) begin
      in_data = $urandom;
      cyc();
    end
    en = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    repeat (5) cyc();

    // Asynchronous reset in the middle of a symbol
    in_valid = 1'b1; in_data = 32'h7777_8888; mode = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    #1;
    q4.delete();
    q1.delete();
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Fully random traffic
    repeat (600) begin
      en        = ($urandom_range(0, 9) != 0);
      clr       = ($urandom_range(0, 24) == 0);
      mode      = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      cyc();
    end
    idle_inputs();
    repeat (6) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
